fp_vector_checker: RTL and testbench

Synthesizable, parametrised stimulus/check engine for the floating-point adder family. It holds a table of packed test vectors {op1, op2, expected result, expected flags} and issues operand pairs to an FP datapath over a valid/ready handshake. It compares the in-order results against the table and reports an error count and the first failing index. It replaces fixed-format, simulation-only vector benches and runs on-chip or in emulation for any operand width and pipeline depth.

---
 rtl/fp_vector_checker_pkg.sv | 25 ++
 rtl/fpvc_vec_mem.sv | 29 ++
 rtl/fp_vector_checker.sv | 148 ++++++++++++++
 tb/tb_fp_vector_checker.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_vector_checker_pkg.sv
// Shared types and vector-layout helpers for the FP vector checker.
// A packed vector is {op1, op2, expected, flags} with op1 in the MSBs.
package fp_vector_checker_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fpvcState_t;

  function automatic int fpvcVecWidth(input int w, input int flagW);
    return 3 * w + flagW;
  endfunction

  function automatic int fpvcOp1Lsb(input int w, input int flagW);
    return 2 * w + flagW;
  endfunction

  function automatic int fpvcOp2Lsb(input int w, input int flagW);
    return w + flagW;
  endfunction

  function automatic int fpvcExpLsb(input int flagW);
    return flagW;
  endfunction

  localparam int FLG_LSB = 0;

endpackage

// File: rtl/fpvc_vec_mem.sv
// Vector table: one synchronous write port, two asynchronous read ports
// (issue side and check side). Contents survive reset.
module fpvc_vec_mem
  import fp_vector_checker_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int VW    = 53,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [VW-1:0] i_wdata,
  input  logic [AW-1:0] i_issAddr,
  output logic [VW-1:0] o_issData,
  input  logic [AW-1:0] i_chkAddr,
  output logic [VW-1:0] o_chkData
);

  logic [VW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_issData = r_mem[i_issAddr];
  assign o_chkData = r_mem[i_chkAddr];

endmodule

// File: rtl/fp_vector_checker.sv
// On-chip stimulus/check engine for FP datapaths: issues table operands over
// valid/ready and checks in-order results. FPVC_FLAG_CHECK_EN also compares flags.
module fp_vector_checker
  import fp_vector_checker_pkg::*;
#(
  parameter int W       = 16,
  parameter int FLAG_W  = 5,
  parameter int DEPTH   = 1024,
  parameter int MAX_OUT = 4,
  localparam int VW     = fpvcVecWidth(W, FLAG_W),
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_we,
  input  logic [AW-1:0]     load_addr,
  input  logic [VW-1:0]     load_data,
  input  logic              start,
  input  logic [CW-1:0]     num_vectors,
  output logic              dut_valid,
  input  logic              dut_ready,
  output logic [W-1:0]      dut_op1,
  output logic [W-1:0]      dut_op2,
  input  logic              res_valid,
  input  logic [W-1:0]      res_data,
  input  logic [FLAG_W-1:0] res_flags,
  output logic              busy,
  output logic              done,
  output logic [CW-1:0]     errors,
  output logic [AW-1:0]     first_err_idx,
  output logic              err_seen,
  output logic              protocol_err
);

  localparam int OW      = $clog2(MAX_OUT + 1);
  localparam int OP1_LSB = fpvcOp1Lsb(W, FLAG_W);
  localparam int OP2_LSB = fpvcOp2Lsb(W, FLAG_W);
  localparam int EXP_LSB = fpvcExpLsb(FLAG_W);

  fpvcState_t    r_state, w_nextState;
  logic [CW-1:0] r_num, r_issIdx, r_chkIdx, r_errors, w_numClamped;
  logic [OW-1:0] r_outstanding;
  logic [AW-1:0] r_firstErrIdx;
  logic          r_errSeen, r_protocolErr;
  logic [VW-1:0] w_issVec, w_chkVec;
  logic          w_idleOrDone, w_startRun, w_issue, w_check, w_mismatch;
  logic          w_dutValid, w_busy, w_done, w_unused;

  fpvc_vec_mem #(.DEPTH(DEPTH), .VW(VW), .AW(AW)) u_mem (
    .clk       (clk),
    .i_we      (load_we),
    .i_waddr   (load_addr),
    .i_wdata   (load_data),
    .i_issAddr (r_issIdx[AW-1:0]),
    .o_issData (w_issVec),
    .i_chkAddr (r_chkIdx[AW-1:0]),
    .o_chkData (w_chkVec)
  );

  assign w_numClamped = (num_vectors > CW'(DEPTH)) ? CW'(DEPTH) : num_vectors;
  assign w_idleOrDone = (r_state == IDLE) || (r_state == DONE);
  assign w_startRun   = w_idleOrDone && start && (w_numClamped != '0);
  assign w_issue      = w_dutValid && dut_ready;
  assign w_check      = res_valid && (r_outstanding != '0);

`ifdef FPVC_FLAG_CHECK_EN
  assign w_mismatch = (res_data != w_chkVec[EXP_LSB +: W]) ||
                      (res_flags != w_chkVec[FLG_LSB +: FLAG_W]);
`else
  assign w_mismatch = (res_data != w_chkVec[EXP_LSB +: W]);
`endif

  // Fields that only some builds or only one read port consume.
  assign w_unused = ^{res_flags, w_chkVec, w_issVec};

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_nextState = (w_numClamped != '0) ? RUN : DONE;
      RUN:        if (w_issue && (r_issIdx + CW'(1) == r_num)) w_nextState = DRAIN;
      DRAIN:      if (w_check && (r_chkIdx + CW'(1) == r_num)) w_nextState = DONE;
      default:    w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_dutValid = (r_state == RUN) && (r_outstanding < OW'(MAX_OUT));
    w_busy     = (r_state == RUN) || (r_state == DRAIN);
    w_done     = (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_num         <= '0;
      r_issIdx      <= '0;
      r_chkIdx      <= '0;
      r_outstanding <= '0;
      r_errors      <= '0;
      r_firstErrIdx <= '0;
      r_errSeen     <= 1'b0;
      r_protocolErr <= 1'b0;
    end else if (w_startRun) begin
      r_num         <= w_numClamped;
      r_issIdx      <= '0;
      r_chkIdx      <= '0;
      r_outstanding <= '0;
      r_errors      <= '0;
      r_firstErrIdx <= '0;
      r_errSeen     <= 1'b0;
      r_protocolErr <= 1'b0;
    end else begin
      if (w_issue) r_issIdx <= r_issIdx + CW'(1);
      if (w_check) begin
        r_chkIdx <= r_chkIdx + CW'(1);
        if (w_mismatch) begin
          if (r_errors != '1) r_errors <= r_errors + CW'(1);
          if (!r_errSeen) begin
            r_firstErrIdx <= r_chkIdx[AW-1:0];
            r_errSeen     <= 1'b1;
          end
        end
      end
      case ({w_issue, w_check})
        2'b10:   r_outstanding <= r_outstanding + OW'(1);
        2'b01:   r_outstanding <= r_outstanding - OW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
      if (res_valid && (r_outstanding == '0)) r_protocolErr <= 1'b1;
    end
  end

  assign dut_valid     = w_dutValid;
  assign dut_op1       = w_issVec[OP1_LSB +: W];
  assign dut_op2       = w_issVec[OP2_LSB +: W];
  assign busy          = w_busy;
  assign done          = w_done;
  assign errors        = r_errors;
  assign first_err_idx = r_firstErrIdx;
  assign err_seen      = r_errSeen;
  assign protocol_err  = r_protocolErr;

endmodule

// File: tb/tb_fp_vector_checker.sv
// Self-checking bench for fp_vector_checker: a latency-configurable datapath
// model answers issued operands and a per-vector reference predicts the verdict.
module tb_fp_vector_checker;

  localparam int W       = 16;
  localparam int FLAG_W  = 5;
  localparam int DEPTH   = 16;
  localparam int MAX_OUT = 4;
  localparam int VW      = 3 * W + FLAG_W;
  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              load_we = 1'b0;
  logic [AW-1:0]     load_addr = '0;
  logic [VW-1:0]     load_data = '0;
  logic              start = 1'b0;
  logic [CW-1:0]     num_vectors = '0;
  logic              dut_ready = 1'b0;
  logic              res_valid = 1'b0;
  logic [W-1:0]      res_data = '0;
  logic [FLAG_W-1:0] res_flags = '0;
  logic              dut_valid, busy, done, err_seen, protocol_err;
  logic [W-1:0]      dut_op1, dut_op2;
  logic [CW-1:0]     errors;
  logic [AW-1:0]     first_err_idx;

  int errorCount = 0;
  int checkCount = 0;
  int lastMaxAhead = 0;

  logic [W-1:0]      tabOp1 [DEPTH];
  logic [W-1:0]      tabOp2 [DEPTH];
  logic [W-1:0]      tabExp [DEPTH];
  logic [FLAG_W-1:0] tabFlg [DEPTH];
  logic [W-1:0]      ans    [DEPTH];
  logic [FLAG_W-1:0] ansFlg [DEPTH];

  fp_vector_checker #(.W(W), .FLAG_W(FLAG_W), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .reset(reset), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .start(start), .num_vectors(num_vectors),
    .dut_valid(dut_valid), .dut_ready(dut_ready), .dut_op1(dut_op1),
    .dut_op2(dut_op2), .res_valid(res_valid), .res_data(res_data),
    .res_flags(res_flags), .busy(busy), .done(done), .errors(errors),
    .first_err_idx(first_err_idx), .err_seen(err_seen), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic loadEntry(input int i);
    load_we   = 1'b1;
    load_addr = AW'(i);
    load_data = {tabOp1[i], tabOp2[i], tabExp[i], tabFlg[i]};
    waitCycle();
    load_we   = 1'b0;
  endtask

  task automatic directedTable();
    for (int i = 0; i < DEPTH; i++) begin
      tabOp1[i] = 16'h3c00; tabOp2[i] = 16'h3c00;
      tabExp[i] = 16'h4000; tabFlg[i] = '0;
      ans[i]    = 16'h4000; ansFlg[i] = '0;
      loadEntry(i);
    end
  endtask

  task automatic randomTable(input int corruptPct, input int flagPct);
    for (int i = 0; i < DEPTH; i++) begin
      tabOp1[i] = W'($urandom); tabOp2[i] = W'($urandom);
      ans[i]    = W'($urandom); ansFlg[i] = FLAG_W'($urandom);
      tabExp[i] = ans[i];       tabFlg[i] = ansFlg[i];
      if ($urandom_range(0, 99) < corruptPct)
        tabExp[i] = ans[i] ^ (W'(1) << $urandom_range(0, W - 1));
      if ($urandom_range(0, 99) < flagPct)
        tabFlg[i] = ansFlg[i] ^ (FLAG_W'(1) << $urandom_range(0, FLAG_W - 1));
      loadEntry(i);
    end
  endtask

  // Reference verdict: walk the first n vectors and compare what the datapath returns.
  task automatic modelRun(input int n, output int expErr, output int expFirst,
                          output bit expSeen);
    bit mism;
    expErr = 0; expFirst = 0; expSeen = 1'b0;
    for (int i = 0; i < n; i++) begin
      mism = (ans[i] != tabExp[i]);
`ifdef FPVC_FLAG_CHECK_EN
      mism = mism || (ansFlg[i] != tabFlg[i]);
`endif
      if (mism) begin
        if (!expSeen) begin expFirst = i; expSeen = 1'b1; end
        if (expErr < (1 << CW) - 1) expErr++;
      end
    end
  endtask

  // readyMode: 0 always ready, 1 random ready, 2 ready dropped for three cycles
  task automatic applyStimulus(input string tag, input int n, input int lat,
                               input int readyMode);
    int nEff, xfer, res, cyc, k, expErr, expFirst, maxAhead, orderErr, stallErr;
    bit expSeen, stalled, firstValid, r;
    logic [W-1:0] sOp1, sOp2;
    int dueQ[$];
    nEff = (n > DEPTH) ? DEPTH : n;
    xfer = 0; res = 0; cyc = 0; maxAhead = 0; orderErr = 0; stallErr = 0;
    stalled = 1'b0; sOp1 = '0; sOp2 = '0;
    start = 1'b1; num_vectors = CW'(n); dut_ready = 1'b0; res_valid = 1'b0;
    waitCycle();
    start = 1'b0;
    firstValid = dut_valid;
    while (!(done && dueQ.size() == 0) && cyc < 3000) begin
      if (stalled && (!dut_valid || dut_op1 != sOp1 || dut_op2 != sOp2)) stallErr++;
      case (readyMode)
        0:       r = 1'b1;
        1:       r = ($urandom_range(0, 9) < 7);
        default: r = !(cyc >= 2 && cyc < 5);
      endcase
      dut_ready = r;
      if (dut_valid && r) begin
        if (xfer >= nEff) orderErr++;
        else if (dut_op1 != tabOp1[xfer] || dut_op2 != tabOp2[xfer]) orderErr++;
        xfer++;
        dueQ.push_back(cyc + lat);
        if (xfer - res > maxAhead) maxAhead = xfer - res;
      end
      stalled = dut_valid && !r;
      sOp1 = dut_op1; sOp2 = dut_op2;
      if (dueQ.size() > 0 && dueQ[0] <= cyc) begin
        k = res % DEPTH;
        res_valid = 1'b1; res_data = ans[k]; res_flags = ansFlg[k];
        void'(dueQ.pop_front());
        res++;
      end else begin
        res_valid = 1'b0; res_data = W'($urandom); res_flags = FLAG_W'($urandom);
      end
      waitCycle();
      cyc++;
    end
    dut_ready = 1'b0; res_valid = 1'b0;
    lastMaxAhead = maxAhead;
    modelRun(nEff, expErr, expFirst, expSeen);
    checkOutput({tag, ".firstValid"}, 64'(firstValid), 64'(1));
    checkOutput({tag, ".done"},       64'(done), 64'(1));
    checkOutput({tag, ".busy"},       64'(busy), 64'(0));
    checkOutput({tag, ".transfers"},  64'(xfer), 64'(nEff));
    checkOutput({tag, ".errors"},     64'(errors), 64'(expErr));
    checkOutput({tag, ".errSeen"},    64'(err_seen), 64'(expSeen));
    checkOutput({tag, ".firstErr"},   64'(first_err_idx), 64'(expFirst));
    checkOutput({tag, ".protoErr"},   64'(protocol_err), 64'(0));
    checkOutput({tag, ".order"},      64'(orderErr), 64'(0));
    checkOutput({tag, ".stable"},     64'(stallErr), 64'(0));
    checkOutput({tag, ".aheadLimit"}, 64'(maxAhead <= MAX_OUT), 64'(1));
  endtask

  task automatic zeroLengthRun();
    int validSeen;
    validSeen = 0;
    start = 1'b1; num_vectors = '0;
    waitCycle();
    start = 1'b0;
    checkOutput("zero.done",  64'(done), 64'(1));
    checkOutput("zero.busy",  64'(busy), 64'(0));
    for (int i = 0; i < 3; i++) begin
      if (dut_valid) validSeen++;
      waitCycle();
    end
    checkOutput("zero.noValid", 64'(validSeen), 64'(0));
  endtask

  task automatic resetMidRun();
    start = 1'b1; num_vectors = CW'(8);
    waitCycle();
    start = 1'b0; dut_ready = 1'b1;
    repeat (3) waitCycle();
    dut_ready = 1'b0;
    reset = 1'b0;
    waitCycle();
    reset = 1'b1;
    checkOutput("midReset.busy",     64'(busy), 64'(0));
    checkOutput("midReset.valid",    64'(dut_valid), 64'(0));
    checkOutput("midReset.protoErr", 64'(protocol_err), 64'(0));
    res_valid = 1'b1; res_data = '0;
    waitCycle();
    res_valid = 1'b0;
    checkOutput("stray.protoErr", 64'(protocol_err), 64'(1));
    checkOutput("stray.busy",     64'(busy), 64'(0));
    checkOutput("stray.errors",   64'(errors), 64'(0));
    waitCycle();
  endtask

  initial begin
    $display("[TB] starting fp_vector_checker bench");
    reset = 1'b0;
    repeat (3) waitCycle();
    checkOutput("reset.valid",    64'(dut_valid), 64'(0));
    checkOutput("reset.busy",     64'(busy), 64'(0));
    checkOutput("reset.done",     64'(done), 64'(0));
    checkOutput("reset.errors",   64'(errors), 64'(0));
    checkOutput("reset.firstErr", 64'(first_err_idx), 64'(0));
    checkOutput("reset.errSeen",  64'(err_seen), 64'(0));
    checkOutput("reset.protoErr", 64'(protocol_err), 64'(0));
    reset = 1'b1;
    waitCycle();

    zeroLengthRun();

    directedTable();
    applyStimulus("basic", 4, 2, 0);

    tabExp[2] = 16'h4001;
    loadEntry(2);
    applyStimulus("corrupt2", 4, 2, 0);
    tabExp[2] = 16'h4000;
    loadEntry(2);

    ansFlg[1] = 5'b00001;
    applyStimulus("flags", 4, 2, 0);
    ansFlg[1] = 5'b00000;

    randomTable(0, 0);
    applyStimulus("stall", 8, 2, 2);
    applyStimulus("lat10", 8, 10, 0);
    checkOutput("lat10.aheadFull", 64'(lastMaxAhead), 64'(MAX_OUT));
    applyStimulus("clamp", 20, 3, 0);

    for (int t = 0; t < 5; t++) begin
      randomTable(25, 20);
      applyStimulus($sformatf("rand%0d", t), $urandom_range(1, DEPTH),
                    $urandom_range(1, 6), 1);
    end

    resetMidRun();
    applyStimulus("afterReset", DEPTH, 3, 1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
